// File: rtl/ray_marcher_if.sv
// Ray request/result and SDF handshake bundle for ray_marcher.
// The master modport is the marcher itself; slave is the requester/SDF side.
interface ray_marcher_if;
    logic               ray_start;
    logic signed [31:0] origin_x;
    logic signed [31:0] origin_y;
    logic signed [31:0] origin_z;
    logic signed [31:0] dir_x;
    logic signed [31:0] dir_y;
    logic signed [31:0] dir_z;
    logic               busy;
    logic               sdf_start;
    logic signed [31:0] sdf_x;
    logic signed [31:0] sdf_y;
    logic signed [31:0] sdf_z;
    logic               sdf_done;
    logic signed [31:0] sdf_dist;
    logic [7:0]         sdf_red;
    logic [7:0]         sdf_green;
    logic [7:0]         sdf_blue;
    logic               ray_done;
    logic               hit;
    logic signed [31:0] depth;
    logic [7:0]         steps;
    logic [7:0]         red_out;
    logic [7:0]         green_out;
    logic [7:0]         blue_out;

    modport master (
        input  ray_start, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z,
        input  sdf_done, sdf_dist, sdf_red, sdf_green, sdf_blue,
        output busy, sdf_start, sdf_x, sdf_y, sdf_z,
        output ray_done, hit, depth, steps, red_out, green_out, blue_out
    );

    modport slave (
        output ray_start, origin_x, origin_y, origin_z, dir_x, dir_y, dir_z,
        output sdf_done, sdf_dist, sdf_red, sdf_green, sdf_blue,
        input  busy, sdf_start, sdf_x, sdf_y, sdf_z,
        input  ray_done, hit, depth, steps, red_out, green_out, blue_out
    );
endinterface

// File: rtl/ray_marcher.sv
// Sphere-tracing controller: marches one ray through menger_sdf until hit, step budget or max distance.
// Optional macro RAY_MARCHER_SHADE_EN darkens the reported colour by 4 per advance (saturating at 0).
module ray_marcher #(
    parameter int                 FRAC_BITS = 16,
    parameter int                 MAX_STEPS = 64,
    parameter logic signed [31:0] MAX_DIST  = 32'sh0064_0000,
    parameter logic signed [31:0] HIT_EPS   = 32'sh0000_0100
) (
    input  logic          clk_in,
    input  logic          rst_in,
    ray_marcher_if.master bus
);
    typedef enum logic [2:0] {IDLE, POINT, WAIT_SDF, EVAL, DONE} state_t;
    state_t state_reg, state_next;

    logic signed [31:0] origin_in [3];
    logic signed [31:0] dir_in    [3];
    logic [7:0]         colour_in [3];

    logic signed [31:0] t_reg, dist_reg, t_adv;
    logic [7:0]         steps_reg, steps_adv;
    logic               hit_reg, is_hit, out_of_range;

    assign origin_in[0] = bus.origin_x;
    assign origin_in[1] = bus.origin_y;
    assign origin_in[2] = bus.origin_z;
    assign dir_in[0]    = bus.dir_x;
    assign dir_in[1]    = bus.dir_y;
    assign dir_in[2]    = bus.dir_z;
    assign colour_in[0] = bus.sdf_red;
    assign colour_in[1] = bus.sdf_green;
    assign colour_in[2] = bus.sdf_blue;

    // Negative distances count as hits: the point already sits inside the surface.
    assign t_adv        = t_reg + dist_reg;
    assign steps_adv    = steps_reg + 8'd1;
    assign is_hit       = (dist_reg <= HIT_EPS);
    assign out_of_range = (t_adv > MAX_DIST) || (steps_adv == 8'(MAX_STEPS));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (bus.ray_start) state_next = POINT;
            POINT:    state_next = WAIT_SDF;
            WAIT_SDF: if (bus.sdf_done) state_next = EVAL;
            EVAL: begin
                if (is_hit || out_of_range) state_next = DONE;
                else                        state_next = POINT;
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            t_reg     <= '0;
            steps_reg <= '0;
            hit_reg   <= 1'b0;
            dist_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ray_start) begin
                        t_reg     <= '0;
                        steps_reg <= '0;
                        hit_reg   <= 1'b0;
                    end
                end
                WAIT_SDF: begin
                    if (bus.sdf_done) dist_reg <= bus.sdf_dist;
                end
                EVAL: begin
                    if (is_hit) begin
                        hit_reg <= 1'b1;
                    end else begin
                        t_reg     <= t_adv;
                        steps_reg <= steps_adv;
                        hit_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic signed [31:0] origin_reg, dir_reg, point_reg;
            logic signed [63:0] prod;

            // Full 64-bit signed product, then arithmetic shift; the 32-bit truncation wraps on overflow.
            assign prod = 64'(dir_reg) * 64'(t_reg);

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    origin_reg <= '0;
                    dir_reg    <= '0;
                    point_reg  <= '0;
                end else begin
                    if (state_reg == IDLE && bus.ray_start) begin
                        origin_reg <= origin_in[gi];
                        dir_reg    <= dir_in[gi];
                    end
                    if (state_reg == POINT) begin
                        point_reg <= origin_reg + 32'(prod >>> FRAC_BITS);
                    end
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_colour
            logic [7:0] colour_reg, colour_out_reg, shaded;
`ifdef RAY_MARCHER_SHADE_EN
            logic [9:0] shade_amt;
            // Darken by the step count that EVAL is about to store.
            assign shade_amt = {(is_hit ? steps_reg : steps_adv), 2'b00};
            assign shaded    = ({2'b00, colour_reg} > shade_amt) ? (colour_reg - shade_amt[7:0]) : 8'd0;
`else
            assign shaded    = colour_reg;
`endif
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    colour_reg     <= '0;
                    colour_out_reg <= '0;
                end else begin
                    if (state_reg == WAIT_SDF && bus.sdf_done) colour_reg <= colour_in[gi];
                    if (state_reg == EVAL) colour_out_reg <= shaded;
                end
            end
        end
    endgenerate

    assign bus.busy      = (state_reg != IDLE);
    assign bus.sdf_start = (state_reg == WAIT_SDF);
    assign bus.ray_done  = (state_reg == DONE);
    assign bus.sdf_x     = g_axis[0].point_reg;
    assign bus.sdf_y     = g_axis[1].point_reg;
    assign bus.sdf_z     = g_axis[2].point_reg;
    assign bus.hit       = hit_reg;
    assign bus.depth     = t_reg;
    assign bus.steps     = steps_reg;
    assign bus.red_out   = g_colour[0].colour_out_reg;
    assign bus.green_out = g_colour[1].colour_out_reg;
    assign bus.blue_out  = g_colour[2].colour_out_reg;
endmodule

// File: tb/tb_ray_marcher.sv
// Self-checking bench for ray_marcher: directed march scenarios plus randomized rays against a march model.
// Honours RAY_MARCHER_SHADE_EN when computing expected colours.
module tb_ray_marcher;
    localparam logic signed [31:0] ONE = 32'sh0001_0000;
`ifdef RAY_MARCHER_SHADE_EN
    localparam int SHADE = 1;
`else
    localparam int SHADE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ray_marcher_if rm_if();
    ray_marcher dut (.clk_in(clk), .rst_in(rst), .bus(rm_if.master));

    int tests_run = 0;
    int tests_failed = 0;

    // SDF stub configuration: L = cycles from sdf_start rising to sdf_done rising.
    int                 stub_lat = 3;
    int                 stub_mode = 0;
    logic signed [31:0] stub_const = 0;
    logic [7:0]         stub_col [3];
    logic signed [31:0] dist_q [$];
    int                 dist_idx = 0;
    logic signed [31:0] seen_x [$];
    logic signed [31:0] seen_y [$];
    logic signed [31:0] seen_z [$];
    int                 unstable = 0;

    function automatic logic [7:0] exp_colour(input logic [7:0] c, input int s);
        int v;
        v = int'(c) - SHADE * 4 * s;
        return (v < 0) ? 8'd0 : 8'(v);
    endfunction

    initial begin : sdf_stub
        int cnt;
        logic signed [31:0] hx, hy, hz;
        cnt = 0; hx = 0; hy = 0; hz = 0;
        rm_if.sdf_done = 1'b0;
        rm_if.sdf_dist = '0;
        rm_if.sdf_red = '0; rm_if.sdf_green = '0; rm_if.sdf_blue = '0;
        forever begin
            @(negedge clk);
            rm_if.sdf_done = 1'b0;
            if (rm_if.sdf_start === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    hx = rm_if.sdf_x; hy = rm_if.sdf_y; hz = rm_if.sdf_z;
                end else if (rm_if.sdf_x !== hx || rm_if.sdf_y !== hy || rm_if.sdf_z !== hz) begin
                    unstable++;
                end
                if (cnt == stub_lat + 1) begin
                    seen_x.push_back(rm_if.sdf_x);
                    seen_y.push_back(rm_if.sdf_y);
                    seen_z.push_back(rm_if.sdf_z);
                    case (stub_mode)
                        0: rm_if.sdf_dist = 32'sh0005_0000 - rm_if.sdf_z;
                        1: rm_if.sdf_dist = stub_const;
                        default: begin
                            rm_if.sdf_dist = (dist_idx < dist_q.size()) ? dist_q[dist_idx] : ONE;
                            dist_idx++;
                        end
                    endcase
                    rm_if.sdf_red   = stub_col[0];
                    rm_if.sdf_green = stub_col[1];
                    rm_if.sdf_blue  = stub_col[2];
                    rm_if.sdf_done  = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic clear_records();
        seen_x.delete(); seen_y.delete(); seen_z.delete();
        dist_idx = 0;
        unstable = 0;
    endtask

    // Launch one ray and wait (bounded) for ray_done; cycles counts the ray_start cycle through the ray_done cycle.
    task automatic run_ray(input logic signed [31:0] ox, oy, oz, dx, dy, dz,
                           output int cycles, output bit timed_out,
                           output logic done_after, output logic busy_after);
        clear_records();
        @(posedge clk); #1;
        rm_if.origin_x = ox; rm_if.origin_y = oy; rm_if.origin_z = oz;
        rm_if.dir_x = dx; rm_if.dir_y = dy; rm_if.dir_z = dz;
        rm_if.ray_start = 1'b1;
        cycles = 0; timed_out = 1'b1; done_after = 1'bx; busy_after = 1'bx;
        for (int k = 1; k <= 20000; k++) begin
            @(posedge clk); #1;
            rm_if.ray_start = 1'b0;
            if (rm_if.ray_done === 1'b1) begin
                cycles = k + 1;
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) begin
            @(posedge clk); #1;
            done_after = rm_if.ray_done;
            busy_after = rm_if.busy;
        end
        $display("[TB] ray dir=(%h,%h,%h): hit=%0d depth=%h steps=%0d evals=%0d cycles=%0d timeout=%0d",
                 dx, dy, dz, rm_if.hit, rm_if.depth, rm_if.steps, seen_z.size(), cycles, timed_out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (rm_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", rm_if.busy); end
        tests_run++; if (rm_if.sdf_start !== 1'b0) begin tests_failed++; $display("FAIL reset sdf_start: got %b expected 0", rm_if.sdf_start); end
        tests_run++; if (rm_if.ray_done !== 1'b0) begin tests_failed++; $display("FAIL reset ray_done: got %b expected 0", rm_if.ray_done); end
        tests_run++;
        if ({rm_if.hit, rm_if.depth, rm_if.steps} !== 41'd0) begin
            tests_failed++; $display("FAIL reset result: got hit=%b depth=%h steps=%0d expected all 0", rm_if.hit, rm_if.depth, rm_if.steps);
        end
        tests_run++;
        if ({rm_if.sdf_x, rm_if.sdf_y, rm_if.sdf_z, rm_if.red_out, rm_if.green_out, rm_if.blue_out} !== 120'd0) begin
            tests_failed++; $display("FAIL reset point/colour: got (%h,%h,%h) rgb=(%0d,%0d,%0d) expected all 0",
                                     rm_if.sdf_x, rm_if.sdf_y, rm_if.sdf_z, rm_if.red_out, rm_if.green_out, rm_if.blue_out);
        end
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_plane_hit();
        int cyc; bit to; logic da, ba; logic signed [31:0] z1;
        stub_lat = 3; stub_mode = 0;
        stub_col[0] = 8'd50; stub_col[1] = 8'd60; stub_col[2] = 8'd70;
        run_ray(0, 0, 0, 0, 0, ONE, cyc, to, da, ba);
        z1 = (seen_z.size() >= 2) ? seen_z[1] : 32'hxxxx_xxxx;
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL plane timeout: no ray_done within budget"); end
        tests_run++; if (rm_if.hit !== 1'b1) begin tests_failed++; $display("FAIL plane hit: got %b expected 1", rm_if.hit); end
        tests_run++; if (rm_if.depth !== 32'h0005_0000) begin tests_failed++; $display("FAIL plane depth: got %h expected 00050000", rm_if.depth); end
        tests_run++; if (rm_if.steps !== 8'd1) begin tests_failed++; $display("FAIL plane steps: got %0d expected 1", rm_if.steps); end
        tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL plane cycles: got %0d expected 14", cyc); end
        tests_run++; if (da !== 1'b0 || ba !== 1'b0) begin tests_failed++; $display("FAIL plane done_pulse: got ray_done=%b busy=%b after pulse expected 0,0", da, ba); end
        tests_run++; if (z1 !== 32'h0005_0000) begin tests_failed++; $display("FAIL plane second_z: got %h expected 00050000", z1); end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (rm_if.hit !== 1'b1 || rm_if.depth !== 32'h0005_0000 || rm_if.steps !== 8'd1) begin
            tests_failed++; $display("FAIL plane hold: got hit=%b depth=%h steps=%0d expected 1,00050000,1", rm_if.hit, rm_if.depth, rm_if.steps);
        end
    endtask

    task automatic test_shading();
        int cyc; bit to; logic da, ba;
        logic [7:0] er, eg, eb;
        er = (SHADE != 0) ? 8'd196 : 8'd200;
        eg = (SHADE != 0) ? 8'd6   : 8'd10;
        eb = (SHADE != 0) ? 8'd0   : 8'd4;
        stub_lat = 3; stub_mode = 0;
        stub_col[0] = 8'd200; stub_col[1] = 8'd10; stub_col[2] = 8'd4;
        run_ray(0, 0, 0, 0, 0, ONE, cyc, to, da, ba);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL shading timeout: no ray_done within budget"); end
        tests_run++; if (rm_if.red_out !== er) begin tests_failed++; $display("FAIL shading red: got %0d expected %0d", rm_if.red_out, er); end
        tests_run++; if (rm_if.green_out !== eg) begin tests_failed++; $display("FAIL shading green: got %0d expected %0d", rm_if.green_out, eg); end
        tests_run++; if (rm_if.blue_out !== eb) begin tests_failed++; $display("FAIL shading blue: got %0d expected %0d", rm_if.blue_out, eb); end
    endtask

    task automatic test_step_budget();
        int cyc; bit to; logic da, ba;
        stub_lat = 1; stub_mode = 1; stub_const = ONE;
        run_ray(0, 0, 0, ONE, 0, 0, cyc, to, da, ba);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL budget timeout: no ray_done within budget"); end
        tests_run++; if (rm_if.hit !== 1'b0) begin tests_failed++; $display("FAIL budget hit: got %b expected 0", rm_if.hit); end
        tests_run++; if (rm_if.steps !== 8'd64) begin tests_failed++; $display("FAIL budget steps: got %0d expected 64", rm_if.steps); end
        tests_run++; if (rm_if.depth !== 32'h0040_0000) begin tests_failed++; $display("FAIL budget depth: got %h expected 00400000", rm_if.depth); end
        tests_run++; if (cyc !== 258) begin tests_failed++; $display("FAIL budget cycles: got %0d expected 258", cyc); end
    endtask

    task automatic test_distance_limit();
        int cyc; bit to; logic da, ba;
        stub_lat = 2; stub_mode = 1; stub_const = 32'sh001E_0000;
        run_ray(0, 0, 0, 0, ONE, 0, cyc, to, da, ba);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL distance timeout: no ray_done within budget"); end
        tests_run++; if (rm_if.hit !== 1'b0) begin tests_failed++; $display("FAIL distance hit: got %b expected 0", rm_if.hit); end
        tests_run++; if (rm_if.steps !== 8'd4) begin tests_failed++; $display("FAIL distance steps: got %0d expected 4", rm_if.steps); end
        tests_run++; if (rm_if.depth !== 32'h0078_0000) begin tests_failed++; $display("FAIL distance depth: got %h expected 00780000", rm_if.depth); end
        tests_run++; if (cyc !== 22) begin tests_failed++; $display("FAIL distance cycles: got %0d expected 22", cyc); end
    endtask

    task automatic test_negative_dir();
        int cyc; bit to; logic da, ba; logic signed [31:0] z1, x_last;
        stub_lat = 2; stub_mode = 1; stub_const = 32'sh0002_0000;
        run_ray(32'sh0003_0000, 32'shFFFE_0000, 0, 0, 0, -ONE, cyc, to, da, ba);
        z1     = (seen_z.size() >= 2) ? seen_z[1] : 32'hxxxx_xxxx;
        x_last = (seen_x.size() >= 1) ? seen_x[seen_x.size() - 1] : 32'hxxxx_xxxx;
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL negdir timeout: no ray_done within budget"); end
        tests_run++; if (z1 !== 32'hFFFE_0000) begin tests_failed++; $display("FAIL negdir second_z: got %h expected fffe0000", z1); end
        tests_run++; if (unstable !== 0) begin tests_failed++; $display("FAIL negdir stable: got %0d point changes during WAIT_SDF expected 0", unstable); end
        tests_run++; if (x_last !== 32'sh0003_0000) begin tests_failed++; $display("FAIL negdir last_x: got %h expected 00030000", x_last); end
        tests_run++;
        if (rm_if.hit !== 1'b0 || rm_if.steps !== 8'd51 || rm_if.depth !== 32'h0066_0000) begin
            tests_failed++; $display("FAIL negdir result: got hit=%b steps=%0d depth=%h expected 0,51,00660000", rm_if.hit, rm_if.steps, rm_if.depth);
        end
        tests_run++; if (cyc !== 257) begin tests_failed++; $display("FAIL negdir cycles: got %0d expected 257", cyc); end
    endtask

    task automatic test_reset_midmarch();
        bit seen_start; int dones;
        stub_lat = 6; stub_mode = 0;
        stub_col[0] = 8'd90; stub_col[1] = 8'd91; stub_col[2] = 8'd92;
        clear_records();
        @(posedge clk); #1;
        rm_if.origin_x = ONE; rm_if.origin_y = ONE; rm_if.origin_z = 32'sh0007_0000;
        rm_if.dir_x = 0; rm_if.dir_y = 0; rm_if.dir_z = ONE;
        rm_if.ray_start = 1'b1;
        seen_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            rm_if.ray_start = 1'b0;
            if (rm_if.sdf_start === 1'b1) begin seen_start = 1'b1; break; end
        end
        tests_run++; if (seen_start !== 1'b1) begin tests_failed++; $display("FAIL midreset reach_wait: got no sdf_start expected 1 within 10 cycles"); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (rm_if.sdf_start !== 1'b0 || rm_if.busy !== 1'b0) begin tests_failed++; $display("FAIL midreset idle: got sdf_start=%b busy=%b expected 0,0", rm_if.sdf_start, rm_if.busy); end
        tests_run++;
        if ({rm_if.hit, rm_if.depth, rm_if.steps, rm_if.sdf_z, rm_if.red_out, rm_if.green_out, rm_if.blue_out} !== 97'd0) begin
            tests_failed++; $display("FAIL midreset outputs: got hit=%b depth=%h steps=%0d z=%h rgb=(%0d,%0d,%0d) expected all 0",
                                     rm_if.hit, rm_if.depth, rm_if.steps, rm_if.sdf_z, rm_if.red_out, rm_if.green_out, rm_if.blue_out);
        end
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (rm_if.ray_done === 1'b1) dones++;
        end
        tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL midreset no_done: got %0d ray_done pulses expected 0", dones); end
        $display("[TB] reset mid-march: ray_done pulses after reset=%0d", dones);
    endtask

    task automatic test_ignored_start();
        int dones; logic signed [31:0] z0, z1;
        stub_lat = 3; stub_mode = 0;
        clear_records();
        @(posedge clk); #1;
        rm_if.origin_x = 0; rm_if.origin_y = 0; rm_if.origin_z = 0;
        rm_if.dir_x = 0; rm_if.dir_y = 0; rm_if.dir_z = ONE;
        rm_if.ray_start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            rm_if.ray_start = (k == 4);
            if (k == 4) rm_if.origin_z = 32'sh0002_0000;
            if (rm_if.ray_done === 1'b1) dones++;
        end
        z0 = (seen_z.size() >= 1) ? seen_z[0] : 32'hxxxx_xxxx;
        z1 = (seen_z.size() >= 2) ? seen_z[1] : 32'hxxxx_xxxx;
        tests_run++; if (dones !== 1) begin tests_failed++; $display("FAIL ignored done_count: got %0d expected 1", dones); end
        tests_run++; if (seen_z.size() !== 2) begin tests_failed++; $display("FAIL ignored evals: got %0d expected 2", seen_z.size()); end
        tests_run++; if (z0 !== 32'h0 || z1 !== 32'h0005_0000) begin tests_failed++; $display("FAIL ignored points: got z0=%h z1=%h expected 00000000,00050000", z0, z1); end
        tests_run++;
        if (rm_if.hit !== 1'b1 || rm_if.depth !== 32'h0005_0000 || rm_if.steps !== 8'd1 || rm_if.busy !== 1'b0) begin
            tests_failed++; $display("FAIL ignored result: got hit=%b depth=%h steps=%0d busy=%b expected 1,00050000,1,0",
                                     rm_if.hit, rm_if.depth, rm_if.steps, rm_if.busy);
        end
        $display("[TB] ignored start: ray_done pulses=%0d evals=%0d", dones, seen_z.size());
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            int o [3]; int dv [3];
            int t, s, n, bad, lat, cyc;
            bit ehit, to; logic da, ba;
            logic [7:0] er, eg, eb;
            for (int a = 0; a < 3; a++) begin
                o[a]  = int'($urandom_range(0, 32'h0010_0000)) - 32'sh0008_0000;
                dv[a] = int'($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000;
            end
            dist_q.delete();
            for (int i = 0; i < 70; i++) begin
                if ($urandom_range(0, 5) == 0) dist_q.push_back(int'($urandom_range(0, 32'h200)) - 32'sh100);
                else                           dist_q.push_back(int'($urandom_range(32'h101, 32'h000C_0000)));
            end
            for (int c = 0; c < 3; c++) stub_col[c] = 8'($urandom_range(0, 255));
            lat = int'($urandom_range(0, 4));
            stub_lat = lat; stub_mode = 2;
            run_ray(o[0], o[1], o[2], dv[0], dv[1], dv[2], cyc, to, da, ba);

            // Reference march: p = o + (dir*t >>> 16), advance by d until hit, budget or distance limit.
            t = 0; s = 0; n = 0; bad = 0; ehit = 1'b0;
            for (int i = 0; i < 70; i++) begin
                int px, py, pz;
                px = o[0] + int'((longint'(dv[0]) * longint'(t)) >>> 16);
                py = o[1] + int'((longint'(dv[1]) * longint'(t)) >>> 16);
                pz = o[2] + int'((longint'(dv[2]) * longint'(t)) >>> 16);
                if (i >= seen_z.size()) bad++;
                else if (seen_x[i] !== px || seen_y[i] !== py || seen_z[i] !== pz) bad++;
                n = i + 1;
                if (dist_q[i] <= 32'sh100) begin ehit = 1'b1; break; end
                t = t + dist_q[i];
                s = s + 1;
                if (t > 32'sh0064_0000 || s == 64) break;
            end
            er = exp_colour(stub_col[0], s);
            eg = exp_colour(stub_col[1], s);
            eb = exp_colour(stub_col[2], s);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL random[%0d] timeout: no ray_done within budget", r); end
            tests_run++; if (rm_if.hit !== ehit) begin tests_failed++; $display("FAIL random[%0d] hit: got %b expected %b", r, rm_if.hit, ehit); end
            tests_run++; if (rm_if.depth !== 32'(t)) begin tests_failed++; $display("FAIL random[%0d] depth: got %h expected %h", r, rm_if.depth, 32'(t)); end
            tests_run++; if (rm_if.steps !== 8'(s)) begin tests_failed++; $display("FAIL random[%0d] steps: got %0d expected %0d", r, rm_if.steps, s); end
            tests_run++; if (seen_z.size() !== n || bad !== 0) begin tests_failed++; $display("FAIL random[%0d] points: got %0d evals with %0d wrong points expected %0d evals, 0 wrong", r, seen_z.size(), bad, n); end
            tests_run++; if (cyc !== n * (lat + 3) + 2) begin tests_failed++; $display("FAIL random[%0d] cycles: got %0d expected %0d", r, cyc, n * (lat + 3) + 2); end
            tests_run++;
            if ({rm_if.red_out, rm_if.green_out, rm_if.blue_out} !== {er, eg, eb}) begin
                tests_failed++; $display("FAIL random[%0d] colour: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", r,
                                         rm_if.red_out, rm_if.green_out, rm_if.blue_out, er, eg, eb);
            end
        end
    endtask

    initial begin
        rm_if.ray_start = 1'b0;
        rm_if.origin_x = '0; rm_if.origin_y = '0; rm_if.origin_z = '0;
        rm_if.dir_x = '0; rm_if.dir_y = '0; rm_if.dir_z = '0;
        stub_col[0] = '0; stub_col[1] = '0; stub_col[2] = '0;
        test_reset();
        test_plane_hit();
        test_shading();
        test_step_budget();
        test_distance_limit();
        test_negative_dir();
        test_reset_midmarch();
        test_ignored_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ray_marcher.md
# ray_marcher

Sphere-tracing controller directly upstream of `menger_sdf`. It accepts one ray (origin plus unit direction, signed Q16.16) and repeatedly computes the sample point `p = origin + t*dir`. Each point is handed to the SDF over the `sdf_start`/`sdf_done` handshake. After each evaluation the ray advances by the returned distance, until it hits the surface, exceeds the step budget or exceeds the maximum distance. It reports hit/miss, depth, step count and the SDF colour to the downstream shader/framebuffer writer.

## Interface
Parameters:
- `FRAC_BITS`, 16: fractional bits of all fixed-point values; total width fixed at 32.
- `MAX_STEPS`, 64: advance budget (1..255).
- `MAX_DIST`, 32'h0064_0000: miss threshold on `t` (100.0).
- `HIT_EPS`, 32'h0000_0100: hit threshold on distance (1/256).

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `ray_start`  in  1  request; sampled only in IDLE.
- `origin_x`, `origin_y`, `origin_z`  in  32 each  signed Q16.16 ray origin.
- `dir_x`, `dir_y`, `dir_z`  in  32 each  signed Q16.16 unit direction.
- `busy`  out  1  high in every state except IDLE.
- `sdf_start`  out  1  level request to SDF.
- `sdf_x`, `sdf_y`, `sdf_z`  out  32 each  sample point.
- `sdf_done`  in  1  SDF result valid.
- `sdf_dist`  in  32  signed Q16.16 distance.
- `sdf_red`, `sdf_green`, `sdf_blue`  in  8 each  surface colour.
- `ray_done`  out  1  one-cycle completion pulse.
- `hit`  out  1  1 = surface hit, 0 = miss.
- `depth`  out  32  final `t`, Q16.16.
- `steps`  out  8  number of advances taken.
- `red_out`, `green_out`, `blue_out`  out  8 each  colour of the last evaluation.

## Operation
States: IDLE, POINT, WAIT_SDF, EVAL, DONE.

- **IDLE**
  - On `ray_start`, latch origin and dir; set `t = 0` and `steps = 0`.
  - Go to POINT.
  - `ray_start` in any other state is ignored.
- **POINT**
  - Register `sdf_x/y/z = origin + ((dir * t) >>> FRAC_BITS)`.
  - The multiply is signed 32x32 giving 64 bits, then an arithmetic shift, then truncation to 32 bits. Overflow wraps; it is not saturated.
  - Go to WAIT_SDF.
- **WAIT_SDF**
  - `sdf_start = 1`; `sdf_x/y/z` are held stable.
  - On `sdf_done`, capture `sdf_dist` and the colour, then go to EVAL.
  - `sdf_done` is ignored in all other states.
- **EVAL**
  - If signed `d <= HIT_EPS` (negative distances included), set `hit = 1` and go to DONE. `t` and `steps` are unchanged.
  - Otherwise set `t' = t + d` and `steps' = steps + 1`.
  - If `t' > MAX_DIST` (signed compare) or `steps' == MAX_STEPS`, set `hit = 0`, store `t'`/`steps'`, and go to DONE.
  - Otherwise store `t'`/`steps'` and go to POINT.
- **DONE**
  - Pulse `ray_done` for one cycle, then return to IDLE.
  - `hit`, `depth`, `steps` and colours hold until the next accepted `ray_start`, which clears `hit`.

Reset:
- Reset returns the block to IDLE. All outputs, `t` and `steps` reset to 0.
- Reset mid-march abandons the ray: `sdf_start` is low on the cycle after reset is sampled, and no `ray_done` is produced.

## Timing
- `sdf_start` rises 2 cycles after `ray_start` is sampled (IDLE→POINT→WAIT_SDF).
- `sdf_start` falls the cycle after `sdf_done` is sampled, and stays low for at least 2 cycles (EVAL, POINT) between evaluations.
- Per-step overhead is 3 cycles plus the SDF latency L; a ray of N evaluations takes N·(L+3)+2 cycles to `ray_done`.
- `busy` falls the same cycle `ray_done` falls, so a new `ray_start` may be accepted on the next cycle.

## Configuration
- `RAY_MARCHER_SHADE_EN`
  - Defined: each colour output is `sat_sub(sdf_colour, steps << 2)`, clamped at 0. This gives step-count darkening, applied in EVAL when the result is stored.
  - Undefined: colours pass through unmodified.
- `hit`, `depth` and `steps` are identical in both builds.

## Test plan
- **Plane hit.** Stub SDF returns `5.0 - z` with L=3; origin (0,0,0), dir (0,0,1.0).
  - First point z=0, d=5.0; second point z=5.0, d=0.
  - Expect `hit=1`, `depth=32'h0005_0000`, `steps=1`, `ray_done` exactly one cycle, total 2·6+2 = 14 cycles.
- **Step budget.** Stub returns constant 1.0.
  - Expect `hit=0`, `steps=64`, `depth=32'h0040_0000`.
- **Distance limit.** Stub returns 30.0.
  - `t` goes 30, 60, 90, 120.
  - Expect `hit=0`, `steps=4`, `depth=32'h0078_0000`.
- **Negative direction.** dir (0,0,-1.0), stub returns 2.0.
  - Expect second `sdf_z = 32'hFFFE_0000`.
  - Check `sdf_x/y/z` are stable for the whole WAIT_SDF window.
- **Reset and ignored start.** Assert `rst_in` during WAIT_SDF.
  - Expect `sdf_start=0` and `busy=0` next cycle, no `ray_done`, all outputs 0.
  - A `ray_start` pulsed while busy is not accepted.
- **Shading.** With `RAY_MARCHER_SHADE_EN`, run the plane-hit case with colour (200,10,4).
  - Expect outputs (196,6,0).
